// File: rtl/bsg_wait_sequencer.sv
// Multi-phase bring-up sequencer: pulses activate_o once per phase into a
// downstream bsg_wait_cycles, then waits for its ready with a per-phase watchdog.
module bsg_wait_sequencer #(
  parameter int num_phases_p = 4,
  parameter int timeout_p    = 256
) (
  input  logic                                                  clk_i,
  input  logic                                                  reset_n_i,
  input  logic                                                  start_i,
  input  logic                                                  abort_i,
  output logic                                                  activate_o,
  input  logic                                                  ready_i,
  output logic [((num_phases_p > 1) ? $clog2(num_phases_p) : 1)-1:0] phase_id_o,
  output logic [num_phases_p-1:0]                               phase_v_o,
  output logic                                                  phase_done_o,
  output logic                                                  busy_o,
  output logic                                                  done_o,
  output logic                                                  error_o,
  output logic [2:0]                                            dbg_state_o
);

  localparam int phase_w_lp = (num_phases_p > 1) ? $clog2(num_phases_p) : 1;
  localparam int cnt_w_lp   = $clog2(timeout_p + 1);
  localparam logic [phase_w_lp-1:0] last_phase_lp = phase_w_lp'(num_phases_p - 1);
  localparam logic [cnt_w_lp-1:0]   timeout_lp    = cnt_w_lp'(timeout_p);
  localparam logic [cnt_w_lp-1:0]   timeout_m1_lp = cnt_w_lp'(timeout_p - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACT   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  state_e                  state_q;
  logic [phase_w_lp-1:0]   phase_q;
  logic [cnt_w_lp-1:0]     cnt_q;
  logic                    activate_q, phase_done_q, busy_q, done_q, error_q;
  logic [num_phases_p-1:0] phase_v_q;

  function automatic logic [num_phases_p-1:0] onehot(input logic [phase_w_lp-1:0] idx);
    return num_phases_p'(1) << idx;
  endfunction

  // Handshake: activate_o is a single-cycle request; the downstream holds
  // ready_i low from the first WAIT cycle until its delay elapses, then raises it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      cnt_q        <= '0;
      activate_q   <= 1'b0;
      phase_done_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      phase_v_q    <= '0;
    end else begin
      activate_q   <= 1'b0;
      phase_done_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      phase_v_q    <= '0;
      if (abort_i) begin
        state_q <= S_IDLE;
        phase_q <= '0;
        cnt_q   <= '0;
        error_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start_i) begin
              state_q    <= S_ACT;
              phase_q    <= '0;
              activate_q <= 1'b1;
              busy_q     <= 1'b1;
              phase_v_q  <= onehot('0);
            end
          end
          S_ACT: begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            phase_v_q <= onehot(phase_q);
          end
          S_WAIT: begin
            cnt_q <= (cnt_q == timeout_lp) ? cnt_q : cnt_q + 1'b1;
            // ready wins over the watchdog when both land on the same cycle
            if (ready_i) begin
              phase_done_q <= 1'b1;
              if (phase_q == last_phase_lp) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q    <= S_ACT;
                phase_q    <= phase_q + 1'b1;
                activate_q <= 1'b1;
                busy_q     <= 1'b1;
                phase_v_q  <= onehot(phase_q + 1'b1);
              end
            end else if (cnt_q == timeout_m1_lp) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end else begin
              busy_q    <= 1'b1;
              phase_v_q <= onehot(phase_q);
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            phase_q <= '0;
          end
          S_ERROR: begin
            if (start_i) begin
              state_q    <= S_ACT;
              phase_q    <= '0;
              error_q    <= 1'b0;
              activate_q <= 1'b1;
              busy_q     <= 1'b1;
              phase_v_q  <= onehot('0);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign activate_o   = activate_q;
  assign phase_id_o   = phase_q;
  assign phase_v_o    = phase_v_q;
  assign phase_done_o = phase_done_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_bsg_wait_sequencer.sv
// Directed bench for bsg_wait_sequencer: a 3-phase/64-cycle instance and a
// 1-phase/8-cycle instance, with cycle-exact expected timelines.
module tb_bsg_wait_sequencer;

  logic       clk, rst_n;
  logic       start, abort, ready;
  logic       act, pdone, done, busy, err;
  logic [1:0] pid;
  logic [2:0] pv, dbg;

  logic       start_b, abort_b, ready_b;
  logic       act_b, pdone_b, done_b, busy_b, err_b;
  logic [0:0] pid_b, pv_b;
  logic [2:0] dbg_b;

  int n_checks = 0;
  int n_pass   = 0;

  bsg_wait_sequencer #(.num_phases_p(3), .timeout_p(64)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .abort_i(abort),
    .activate_o(act), .ready_i(ready), .phase_id_o(pid), .phase_v_o(pv),
    .phase_done_o(pdone), .busy_o(busy), .done_o(done), .error_o(err),
    .dbg_state_o(dbg)
  );

  bsg_wait_sequencer #(.num_phases_p(1), .timeout_p(8)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start_b), .abort_i(abort_b),
    .activate_o(act_b), .ready_i(ready_b), .phase_id_o(pid_b), .phase_v_o(pv_b),
    .phase_done_o(pdone_b), .busy_o(busy_b), .done_o(done_b), .error_o(err_b),
    .dbg_state_o(dbg_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 0; abort = 0; ready = 0;
    start_b = 0; abort_b = 0; ready_b = 0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({act, pdone, done, busy, err, pv, pid} !== 10'd0)
      $display("FAIL reset_main obs=%b exp=%b", {act, pdone, done, busy, err, pv, pid}, 10'd0);
    else n_pass++;
    n_checks++;
    if ({act_b, pdone_b, done_b, busy_b, err_b, pv_b, pid_b} !== 7'd0)
      $display("FAIL reset_b obs=%b exp=%b", {act_b, pdone_b, done_b, busy_b, err_b, pv_b, pid_b}, 7'd0);
    else n_pass++;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  // {activate, phase_done, done, busy, error, phase_v[2:0], phase_id[1:0]}
  task automatic test_normal();
    logic [9:0] obs, exp;
    logic       b;
    logic [1:0] ph;
    int         c;
    for (int e = 0; e < 120; e++) begin
      start = (e == 10);
      ready = (e == 44 || e == 78 || e == 112);
      step();
      c  = e + 1;
      b  = (c >= 11 && c <= 112);
      ph = (c < 45) ? 2'd0 : (c < 79) ? 2'd1 : 2'd2;
      exp = {c == 11 || c == 45 || c == 79, c == 45 || c == 79 || c == 113, c == 113,
             b, 1'b0, b ? (3'b001 << ph) : 3'b000, b ? ph : 2'd0};
      obs = {act, pdone, done, busy, err, pv, b ? pid : 2'd0};
      n_checks++;
      if (obs !== exp) $display("FAIL normal cycle=%0d obs=%b exp=%b", c, obs, exp);
      else n_pass++;
    end
    start = 0; ready = 0;
  endtask

  task automatic test_timeout();
    logic [9:0] obs, exp;
    logic       b, er;
    logic [1:0] ph;
    int         c;
    for (int e = 0; e < 120; e++) begin
      start = (e == 10);
      ready = (e == 44);
      step();
      c  = e + 1;
      b  = (c >= 11 && c <= 109);
      er = (c >= 110);
      ph = (c < 45) ? 2'd0 : 2'd1;
      exp = {c == 11 || c == 45, c == 45, 1'b0, b, er,
             b ? (3'b001 << ph) : 3'b000, (b || er) ? ph : 2'd0};
      obs = {act, pdone, done, busy, err, pv, (b || er) ? pid : 2'd0};
      n_checks++;
      if (obs !== exp) $display("FAIL timeout cycle=%0d obs=%b exp=%b", c, obs, exp);
      else n_pass++;
    end
    start = 1; ready = 0;
    step();
    start = 0;
    n_checks++;
    if ({act, pdone, done, busy, err, pv, pid} !== 10'b1_0_0_1_0_001_00)
      $display("FAIL timeout_restart obs=%b exp=%b", {act, pdone, done, busy, err, pv, pid}, 10'b1001000100);
    else n_pass++;
    abort = 1;
    step();
    abort = 0;
    n_checks++;
    if ({act, pdone, done, busy, err, pv, pid} !== 10'd0)
      $display("FAIL timeout_abort obs=%b exp=%b", {act, pdone, done, busy, err, pv, pid}, 10'd0);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [9:0] obs, exp;
    logic       b, show;
    logic [1:0] ph;
    int         c;
    for (int e = 0; e < 100; e++) begin
      start = (e == 10 || e == 95);
      abort = (e == 90 || e == 95);
      ready = (e == 44 || e == 78 || e == 90);
      step();
      c    = e + 1;
      b    = (c >= 11 && c <= 90);
      show = (c >= 11);
      ph   = (c < 45) ? 2'd0 : (c < 79) ? 2'd1 : (c <= 90) ? 2'd2 : 2'd0;
      exp = {c == 11 || c == 45 || c == 79, c == 45 || c == 79, 1'b0,
             b, 1'b0, b ? (3'b001 << ph) : 3'b000, show ? ph : 2'd0};
      obs = {act, pdone, done, busy, err, pv, show ? pid : 2'd0};
      n_checks++;
      if (obs !== exp) $display("FAIL abort cycle=%0d obs=%b exp=%b", c, obs, exp);
      else n_pass++;
    end
    start = 0; abort = 0; ready = 0;
  endtask

  // {activate, phase_done, done, busy, error, phase_v, phase_id}
  task automatic test_boundary();
    logic [6:0] obs, exp;
    logic       b;
    int         c;
    for (int e = 0; e < 41; e++) begin
      start_b = (e == 2 || e == 10 || e == 25);
      ready_b = (e == 4 || e == 19);
      abort_b = (e == 38);
      step();
      c = e + 1;
      b = (c >= 3 && c <= 4) || (c >= 11 && c <= 19) || (c >= 26 && c <= 34);
      exp = {c == 3 || c == 11 || c == 26, c == 5 || c == 20, c == 5 || c == 20,
             b, (c >= 35 && c <= 38), b, 1'b0};
      obs = {act_b, pdone_b, done_b, busy_b, err_b, pv_b, pid_b};
      n_checks++;
      if (obs !== exp) $display("FAIL boundary cycle=%0d obs=%b exp=%b", c, obs, exp);
      else n_pass++;
    end
    start_b = 0; ready_b = 0; abort_b = 0;
  endtask

  task automatic test_async_reset();
    start = 1;
    step();
    start = 0;
    n_checks++;
    if ({act, busy} !== 2'b11) $display("FAIL arst_pre obs=%b exp=%b", {act, busy}, 2'b11);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({act, busy, pv} !== 5'd0) $display("FAIL arst_immediate obs=%b exp=%b", {act, busy, pv}, 5'd0);
    else n_pass++;
    #2 rst_n = 1'b1;
    step();
    start = 1;
    step();
    start = 0;
    n_checks++;
    if ({act, pdone, done, busy, err, pv, pid} !== 10'b1_0_0_1_0_001_00)
      $display("FAIL arst_restart obs=%b exp=%b", {act, pdone, done, busy, err, pv, pid}, 10'b1001000100);
    else n_pass++;
    step();
    n_checks++;
    if ({act, pdone, done, busy, err, pv, pid} !== 10'b0_0_0_1_0_001_00)
      $display("FAIL arst_wait obs=%b exp=%b", {act, pdone, done, busy, err, pv, pid}, 10'b0001000100);
    else n_pass++;
    abort = 1;
    step();
    abort = 0;
  endtask

  task automatic test_back_to_back();
    logic [9:0] obs, exp;
    logic       b;
    logic [1:0] ph;
    int         c;
    for (int e = 0; e < 106; e++) begin
      start = 1;
      ready = (e == 34 || e == 68 || e == 102);
      step();
      c  = e + 1;
      b  = (c >= 1 && c <= 102) || (c >= 105);
      ph = (c >= 105 || c < 35) ? 2'd0 : (c < 69) ? 2'd1 : 2'd2;
      exp = {c == 1 || c == 35 || c == 69 || c == 105, c == 35 || c == 69 || c == 103, c == 103,
             b, 1'b0, b ? (3'b001 << ph) : 3'b000, b ? ph : 2'd0};
      obs = {act, pdone, done, busy, err, pv, b ? pid : 2'd0};
      n_checks++;
      if (obs !== exp) $display("FAIL back_to_back cycle=%0d obs=%b exp=%b", c, obs, exp);
      else n_pass++;
    end
    start = 0; ready = 0;
    abort = 1;
    step();
    abort = 0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_abort();
    test_boundary();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bsg_wait_sequencer.md
# bsg_wait_sequencer

Multi-phase bring-up sequencer that sits directly upstream of `bsg_wait_cycles`. It walks through `num_phases_p` phases. For each phase it pulses `activate_o` into the wait-cycles counter, then holds until that counter's `ready_r_o` (arriving here as `ready_i`) reports the delay has elapsed. It reports per-phase progress, overall completion, and a sticky watchdog error if a phase never completes.

## Interface
- `num_phases_p`, default 4: number of phases; legal range 1–16.
- `timeout_p`, default 256: maximum WAIT-state cycles per phase before an error is flagged; must be at least 2.
- `clk_i`, input, 1: sole clock; everything is posedge.
- `reset_n_i`, input, 1: reset, asynchronous and active-low.
- `start_i`, input, 1: begin a sequence; sampled in IDLE and ERROR only.
- `abort_i`, input, 1: abandon the current sequence.
- `activate_o`, output, 1: one-cycle pulse to the downstream `activate_i`.
- `ready_i`, input, 1: downstream `ready_r_o`.
- `phase_id_o`, output, `$clog2(num_phases_p)` bits (minimum 1): index of the current phase.
- `phase_v_o`, output, `num_phases_p` bits: one-hot of the current phase; all-zero in IDLE, DONE and ERROR.
- `phase_done_o`, output, 1: one-cycle pulse when a phase's wait completes.
- `busy_o`, output, 1: high in ACT and WAIT.
- `done_o`, output, 1: one-cycle pulse after the last phase completes.
- `error_o`, output, 1: sticky watchdog error.

## Operation
- **States:** IDLE, ACT, WAIT, DONE, ERROR.
- **Output registers:** all outputs are registered.
- **Reset values** (asynchronous, on `reset_n_i`=0):
  - state = IDLE, phase index = 0, wait counter = 0.
  - `activate_o`, `phase_done_o`, `busy_o`, `done_o`, `error_o` all 0; `phase_v_o` = 0.
- **IDLE:**
  - `start_i`=1 and `abort_i`=0: go to ACT with phase 0.
  - Otherwise stay in IDLE.
- **ACT** (exactly one cycle):
  - `activate_o`=1.
  - Wait counter cleared.
  - `ready_i` ignored.
  - Next state is WAIT.
- **WAIT:**
  - Wait counter increments every cycle, saturating at `timeout_p`.
  - `ready_i`=1, not the last phase: raise `phase_done_o` and go to ACT with phase+1.
  - `ready_i`=1, last phase: raise `phase_done_o` and go to DONE.
  - `ready_i`=0 with counter == `timeout_p`-1: go to ERROR.
  - `ready_i` sampled high on the timeout cycle: treated as success; success beats timeout.
- **DONE** (one cycle): `done_o`=1, then IDLE.
- **ERROR:**
  - `error_o`=1 and sticky.
  - `phase_id_o` holds the failing phase.
  - `start_i` clears `error_o` and goes to ACT with phase 0.
  - `abort_i` clears `error_o` and goes to IDLE.
  - If both are high, `abort_i` wins.
- **Abort:** `abort_i`=1 in any state gives IDLE next cycle.
  - No `done_o` or `phase_done_o` is raised.
  - Phase index is reset to 0.
  - `activate_o` is not pulsed that cycle.
  - `abort_i` has priority over `start_i`, `ready_i` and timeout.
- **Ignored start:** `start_i` has no effect in ACT, WAIT and DONE.
- **Downstream contract:** the downstream block must drive `ready_i` low by the first WAIT cycle, i.e. one cycle after the `activate_o` cycle. `bsg_wait_cycles` meets this.
- **Mid-operation reset:** asynchronous reset during any state forces the reset values immediately. A downstream `activate_o` pulse is therefore cut short.

## Timing
- `start_i` sampled at edge t: ACT is cycle t+1 (`activate_o`=1, `busy_o`=1, `phase_v_o`=0001); WAIT begins at cycle t+2.
- `ready_i`=1 sampled in WAIT at edge w:
  - `phase_done_o`=1 during cycle w+1.
  - During that same cycle, either the next ACT (`activate_o`=1) or DONE (`done_o`=1, `busy_o`=0).
- Per-phase overhead beyond the downstream delay: exactly 1 cycle (ACT).
- Timeout: ERROR entered at cycle t+2+`timeout_p`, where t+1 is the ACT cycle.
- No combinational path from any input to any output.

## Test plan
- **Normal run.** `num_phases_p`=3, `timeout_p`=64, bench model raises `ready_i` 33 cycles after each `activate_o` (matching a 32-cycle `bsg_wait_cycles`). Pulse `start_i` at edge 10.
  - Required: `activate_o` pulses at cycles 11, 45 and 79.
  - Required: `phase_done_o` at cycles 45, 79 and 113.
  - Required: `done_o` at cycle 113, never `error_o`, `phase_id_o` reading 0→1→2.
- **Timeout.** Same configuration, with `ready_i` held low in phase 1.
  - Required: `error_o` rises at cycle 45+1+64 = 110 and stays high, `phase_id_o`=1, no `done_o`.
  - Then pulse `start_i`: `error_o` clears and phase 0 restarts.
- **Abort mid-WAIT.** Assert `abort_i` together with `ready_i` in phase 2.
  - Required: IDLE next cycle, no `phase_done_o`, no `done_o`, `busy_o`=0, `phase_v_o`=0.
  - Also required: `start_i` and `abort_i` asserted together in IDLE leaves the block in IDLE.
- **Boundary.** `num_phases_p`=1 with `ready_i` arriving on the first WAIT cycle.
  - Required: `activate_o` at t+1, `phase_done_o` and `done_o` at t+3.
  - Also required: `ready_i` arriving on cycle `timeout_p`-1 counts as success, with no error.
- **Async reset.** Drop `reset_n_i` mid-ACT between clock edges.
  - Required: `activate_o` and `busy_o` go low immediately, without waiting for a clock edge.
  - After release, `start_i` runs a clean sequence from phase 0.
- **Ignored start.** `start_i` held high throughout a run.
  - Required: no restart while busy.
  - Required: a new sequence begins only after the DONE→IDLE transition, at cycle done+2.
